// File: rtl/mic_frame_pkg.sv
// Shared types and helpers for the microphone frame writer: FSM states,
// mailbox word layout and the frame/block word-count arithmetic.
package mic_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WRITE,
        S_BLOCK_DONE,
        S_POST,
        S_POLL_RD,
        S_POLL_CHK
    } state_t;

    localparam int MBOX_VALID   = 0;
    localparam int MBOX_BANK    = 1;
    localparam int MBOX_OVR     = 2;
    localparam int MBOX_SEQ_LSB = 8;

    // Two 16-bit samples share one 32-bit RAM word.
    function automatic int words_per_frame(input int mic_n);
        return mic_n / 2;
    endfunction

    function automatic int words_per_block(input int mic_n, input int frames);
        return frames * (mic_n / 2);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a history
// flop that turns each synchronised rising edge into a one-cycle pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [1:0] sync;
    logic       hist;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            hist <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            hist <= sync[1];
        end
    end

    assign rise = sync[1] & ~hist;

endmodule

// File: rtl/mic_frame_writer.sv
// Packs decimated PCM frames into ping-pong RAM banks, posts each finished
// block through a mailbox word and holds irq until the host clears it.
module mic_frame_writer
    import mic_frame_pkg::*;
#(
    parameter int MIC_N     = 2,
    parameter int SAMPLE_W  = 16,
    parameter int FRAMES    = 8,
    parameter int ADDR_W    = 7,
    parameter int MBOX_ADDR = 127,
    parameter int POLL_GAP  = 16
) (
    input  logic                      sys_clk,
    input  logic                      core_reset_n,
    input  logic                      enable,
    input  logic                      sample_valid,
    input  logic [MIC_N*SAMPLE_W-1:0] sample_data,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [31:0]               ram_writedata,
    output logic [3:0]                ram_byteenable,
    input  logic [31:0]               ram_readdata,
    output logic                      irq,
    output logic [7:0]                drop_count
);

    localparam int WPF    = words_per_frame(MIC_N);
    localparam int WPB    = words_per_block(MIC_N, FRAMES);
    localparam int WORD_W = 2 * SAMPLE_W;
    localparam int W_W    = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int FI_W   = $clog2(FRAMES + 1);
    localparam int PG_W   = $clog2(POLL_GAP + 1);

    state_t                    state, state_next;
    logic [MIC_N*SAMPLE_W-1:0] data_q;
    logic [W_W-1:0]            w_idx;
    logic [FI_W-1:0]           frame_idx;
    logic                      bank;
    logic [7:0]                seq;
    logic                      pending;
    logic                      ovr;
    logic                      frame_flag;
    logic [PG_W-1:0]           poll_cnt;
    logic                      rise;
    logic                      last_word;
    logic                      last_frame;
    logic [ADDR_W-1:0]         word_addr;
    logic [31:0]               mbox_word;

    edge_sync u_edge_sync (
        .clk   (sys_clk),
        .rst_n (core_reset_n),
        .din   (sample_valid),
        .rise  (rise)
    );

    assign last_word  = (w_idx == W_W'(WPF - 1));
    assign last_frame = (frame_idx == FI_W'(FRAMES - 1));
    assign word_addr  = ADDR_W'(int'(bank) * WPB + int'(frame_idx) * WPF + int'(w_idx));

    always_comb begin
        mbox_word                          = '0;
        mbox_word[MBOX_VALID]              = 1'b1;
        mbox_word[MBOX_BANK]               = bank;
        mbox_word[MBOX_OVR]                = ovr;
        mbox_word[MBOX_SEQ_LSB +: 8]       = seq;
    end

    always_ff @(posedge sys_clk or negedge core_reset_n) begin
        if (!core_reset_n) state <= S_IDLE;
        else               state <= state_next;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_writedata  = '0;
        case (state)
            S_IDLE: begin
                if (frame_flag)                    state_next = S_CAPTURE;
                else if (pending && poll_cnt == '0) state_next = S_POLL_RD;
            end
            S_CAPTURE: state_next = S_WRITE;
            S_WRITE: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = word_addr;
                ram_writedata  = data_q[int'(w_idx) * WORD_W +: WORD_W];
                if (last_word) state_next = last_frame ? S_BLOCK_DONE : S_IDLE;
            end
            S_BLOCK_DONE: state_next = pending ? S_IDLE : S_POST;
            S_POST: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = ADDR_W'(MBOX_ADDR);
                ram_writedata  = mbox_word;
                state_next     = S_IDLE;
            end
            S_POLL_RD: begin
                ram_chipselect = 1'b1;
                ram_address    = ADDR_W'(MBOX_ADDR);
                state_next     = S_POLL_CHK;
            end
            S_POLL_CHK: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            data_q     <= '0;
            w_idx      <= '0;
            frame_idx  <= '0;
            bank       <= 1'b0;
            seq        <= 8'd0;
            pending    <= 1'b0;
            ovr        <= 1'b0;
            frame_flag <= 1'b0;
            poll_cnt   <= '0;
            drop_count <= 8'd0;
        end else begin
            // An edge arriving while a frame is still flagged is absorbed.
            frame_flag <= (frame_flag && state != S_CAPTURE) || (rise && enable);
            if (poll_cnt != '0) poll_cnt <= poll_cnt - 1'b1;
            case (state)
                S_CAPTURE: begin
                    data_q <= sample_data;
                    w_idx  <= '0;
                end
                S_WRITE: begin
                    w_idx <= w_idx + 1'b1;
                    if (last_word) frame_idx <= frame_idx + 1'b1;
                end
                S_BLOCK_DONE: begin
                    // Host still owns the previous block: overwrite this bank.
                    if (pending) begin
                        frame_idx <= '0;
                        ovr       <= 1'b1;
                        if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
                    end
                end
                S_POST: begin
                    pending   <= 1'b1;
                    ovr       <= 1'b0;
                    seq       <= seq + 1'b1;
                    bank      <= ~bank;
                    frame_idx <= '0;
                    poll_cnt  <= PG_W'(POLL_GAP);
                end
                S_POLL_CHK: begin
                    if (ram_readdata == 32'd0) pending <= 1'b0;
                    poll_cnt <= PG_W'(POLL_GAP);
                end
                default: ;
            endcase
        end
    end

    assign irq            = pending;
    assign ram_byteenable = 4'hF;

endmodule
